// File: rtl/csram_arbiter.sv
// csram_arbiter: two-port request/ack arbiter and registered access sequencer for the asynchronous csram
module csram_arbiter #(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 16,
  parameter int WAIT_STATES = 0
) (
  input  logic              in_clock,
  input  logic              in_reset,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_ack,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_ack,
  output logic [DATA_W-1:0] b_rdata,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_oe,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);
  typedef enum logic [2:0] {IDLE, SETUP, WAIT, STROBE, DONE} state_t;
  localparam logic [3:0] WS_LAST = 4'(WAIT_STATES - 1);
  state_t state;
  logic owner_b, last_b, op_we;
  logic [3:0] cnt;
  logic grant_b, last_cycle;
  // B wins only when A is idle or A owned the previous grant
  assign grant_b = b_req & (~a_req | ~last_b);
  assign last_cycle = (state == SETUP && WAIT_STATES == 0) || (state == WAIT && cnt == WS_LAST);
  always_ff @(posedge in_clock or negedge in_reset) begin
    if (!in_reset) begin
      state <= IDLE;
      owner_b <= 1'b0;
      last_b <= 1'b1;
      op_we <= 1'b0;
      cnt <= '0;
      a_ack <= 1'b0;
      b_ack <= 1'b0;
      a_rdata <= '0;
      b_rdata <= '0;
      mem_address <= '0;
      mem_wdata <= '0;
      mem_oe <= 1'b0;
      mem_we <= 1'b0;
      busy <= 1'b0;
    end else begin
      a_ack <= 1'b0;
      b_ack <= 1'b0;
      case (state)
        IDLE: if (a_req | b_req) begin
          owner_b <= grant_b;
          last_b <= grant_b;
          op_we <= grant_b ? b_we : a_we;
          mem_address <= grant_b ? b_addr : a_addr;
          mem_wdata <= grant_b ? b_wdata : a_wdata;
          mem_oe <= ~(grant_b ? b_we : a_we);
          cnt <= '0;
          busy <= 1'b1;
          state <= SETUP;
        end
        SETUP, WAIT: if (!last_cycle) begin
          if (state == WAIT) cnt <= cnt + 4'd1;
          state <= WAIT;
        end else if (op_we) begin
          mem_we <= 1'b1;
          state <= STROBE;
        end else begin
          if (owner_b) b_rdata <= mem_rdata;
          else a_rdata <= mem_rdata;
          a_ack <= ~owner_b;
          b_ack <= owner_b;
          mem_oe <= 1'b0;
          state <= DONE;
        end
        STROBE: begin
          mem_we <= 1'b0;
          a_ack <= ~owner_b;
          b_ack <= owner_b;
          state <= DONE;
        end
        DONE: begin
          busy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_csram_arbiter.sv
// tb_csram_arbiter: directed scoreboard bench for csram_arbiter with a behavioural csram model
module tb_csram_arbiter;
  localparam int WS = 2;
  logic in_clock = 1'b0, in_reset = 1'b0;
  logic a_req = 0, a_we = 0, b_req = 0, b_we = 0;
  logic [15:0] a_addr = 0, a_wdata = 0, b_addr = 0, b_wdata = 0;
  logic a_ack, b_ack, mem_oe, mem_we, busy;
  logic [15:0] a_rdata, b_rdata, mem_address, mem_wdata, mem_rdata;
  logic [15:0] mem [0:255];
  logic [15:0] ref_mem [0:255];
  logic mem_init = 1'b1;
  typedef struct packed {logic port; logic rd; logic [15:0] data;} exp_t;
  exp_t sb[$];
  exp_t e;
  int errors = 0, checks = 0;
  logic pa = 0, pb = 0, prev_ok = 0;
  logic [15:0] pra = 0, prb = 0;

  csram_arbiter #(.ADDR_W(16), .DATA_W(16), .WAIT_STATES(WS)) dut (
    .in_clock(in_clock), .in_reset(in_reset),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata), .a_ack(a_ack), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata), .b_ack(b_ack), .b_rdata(b_rdata),
    .mem_address(mem_address), .mem_wdata(mem_wdata), .mem_oe(mem_oe), .mem_we(mem_we),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 in_clock = ~in_clock;

  function automatic logic [15:0] init_val(input logic [7:0] a);
    return (a == 8'h10) ? 16'h1234 : {a, ~a};
  endfunction

  assign mem_rdata = mem[mem_address[7:0]];
  always @(posedge in_clock) begin
    if (mem_init) for (int i = 0; i < 256; i++) mem[i] <= init_val(8'(i));
    else if (mem_we) mem[mem_address[7:0]] <= mem_wdata;
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Scoreboard monitor: every ack pops the oldest expected response
  always @(negedge in_clock) begin
    if (in_reset) begin
      chk("we_oe_excl", {31'b0, mem_we & mem_oe}, 0);
      if (a_ack | b_ack) begin
        chk("ack_excl", {31'b0, a_ack & b_ack}, 0);
        chk("ack_one_cycle", {31'b0, (a_ack & pa) | (b_ack & pb)}, 0);
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_ack: a_ack=%b b_ack=%b with empty scoreboard", a_ack, b_ack);
        end else begin
          e = sb.pop_front();
          chk("ack_port", {31'b0, b_ack}, {31'b0, e.port});
          if (e.rd) chk("rdata", {16'b0, b_ack ? b_rdata : a_rdata}, {16'b0, e.data});
        end
      end
      if (prev_ok) chk("rdata_hold", {31'b0, (a_rdata !== pra && !a_ack) || (b_rdata !== prb && !b_ack)}, 0);
    end
    pa = a_ack; pb = b_ack; pra = a_rdata; prb = b_rdata; prev_ok = in_reset;
  end

  task automatic wait_idle();
    for (int i = 0; i < 20 && busy; i++) @(negedge in_clock);
  endtask

  task automatic expect_op(input logic port, input logic we, input logic [15:0] addr, input logic [15:0] wd);
    sb.push_back(exp_t'{port, ~we, ref_mem[addr[7:0]]});
    if (we) ref_mem[addr[7:0]] = wd;
  endtask

  task automatic access(input logic port, input logic we, input logic [15:0] addr, input logic [15:0] wd);
    int n, we_hi, we_at, addr_bad;
    logic got;
    wait_idle();
    expect_op(port, we, addr, wd);
    if (port) begin b_we = we; b_addr = addr; b_wdata = wd; b_req = 1; end
    else begin a_we = we; a_addr = addr; a_wdata = wd; a_req = 1; end
    n = 0; got = 0; we_hi = 0; we_at = 0; addr_bad = 0;
    while (!got && n < 50) begin
      @(negedge in_clock);
      n++;
      if (mem_we) begin we_hi++; we_at = n; end
      if (mem_address != addr) addr_bad++;
      got = port ? b_ack : a_ack;
    end
    a_req = 0; b_req = 0;
    chk("ack_seen", {31'b0, got}, 1);
    chk("latency", n, (we ? 3 : 2) + WS);
    chk("we_pulses", we_hi, we ? 1 : 0);
    if (we) chk("we_cycle", we_at, 2 + WS);
    chk("addr_stable", addr_bad, 0);
  endtask

  task automatic wait_acks(input int n, input logic drop_b);
    int seen = 0, k = 0;
    while (seen < n && k < 100) begin
      @(negedge in_clock);
      k++;
      if (a_ack | b_ack) seen++;
      if (drop_b && b_ack) b_req = 0;
    end
    chk("ack_count", seen, n);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ref_mem[i] = init_val(8'(i));
    repeat (3) @(negedge in_clock);
    chk("rst_outputs", {a_ack, b_ack, mem_oe, mem_we, busy}, 0);
    chk("rst_rdata", {a_rdata, b_rdata}, 0);
    chk("rst_mem_bus", {mem_address, mem_wdata}, 0);
    mem_init = 0;
    in_reset = 1;
    @(negedge in_clock);
    access(0, 0, 16'h0010, 0);
    access(1, 1, 16'h0020, 16'hBEEF);
    access(1, 0, 16'h0020, 0);
    // Continuous contention: grants must alternate starting with A
    wait_idle();
    expect_op(0, 0, 16'h0011, 0); expect_op(1, 0, 16'h0021, 0);
    expect_op(0, 0, 16'h0011, 0); expect_op(1, 0, 16'h0021, 0);
    a_we = 0; a_addr = 16'h0011; b_we = 0; b_addr = 16'h0021; a_req = 1; b_req = 1;
    wait_acks(4, 0);
    a_req = 0; b_req = 0;
    // A holds req, changes addr after grant; B arrives mid-transaction
    wait_idle();
    expect_op(0, 0, 16'h0030, 0);
    a_we = 0; a_addr = 16'h0030; a_req = 1;
    @(negedge in_clock);
    a_addr = 16'h0020;
    b_we = 1; b_addr = 16'h0040; b_wdata = 16'h5555; b_req = 1;
    expect_op(1, 1, 16'h0040, 16'h5555);
    expect_op(0, 0, 16'h0020, 0);
    wait_acks(3, 1);
    a_req = 0; b_req = 0;
    access(1, 0, 16'h0040, 0);
    // Reset during STROBE of an A write
    wait_idle();
    a_we = 1; a_addr = 16'h0050; a_wdata = 16'h7777; a_req = 1;
    for (int i = 0; i < 20 && !mem_we; i++) @(negedge in_clock);
    chk("strobe_seen", {31'b0, mem_we}, 1);
    in_reset = 0;
    a_req = 0;
    #1;
    chk("midrst_ctrl", {a_ack, b_ack, mem_oe, mem_we, busy}, 0);
    chk("midrst_bus", {mem_address, mem_wdata}, 0);
    chk("midrst_rdata", {a_rdata, b_rdata}, 0);
    @(negedge in_clock);
    #2 in_reset = 1;
    @(negedge in_clock);
    expect_op(0, 0, 16'h0011, 0); expect_op(1, 0, 16'h0021, 0);
    a_we = 0; a_addr = 16'h0011; b_we = 0; b_addr = 16'h0021; a_req = 1; b_req = 1;
    wait_acks(2, 1);
    a_req = 0; b_req = 0;
    for (int i = 0; i < 24; i++)
      access(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 16'h0060 + 16'($urandom_range(0, 7)), 16'($urandom));
    repeat (4) @(negedge in_clock);
    chk("sb_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
